// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame engine.
// Covers the one-hot frame states, the parity and stop-bit encodings, and the parity helper.
package uart_tx_pkg;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Odd parity is the complement of the plain XOR reduction of the word.
  function automatic logic parity_bit(input logic even_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~even_xor : even_xor;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Handshake bundle between the TX data source (master) and the frame engine (slave).
// The serial line and the status flags are carried in the same bundle.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic                  TX_OUT;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output P_DATA,
    output Data_valid,
    output PAR_EN,
    output PAR_TYP,
    output STOP2,
    input  TX_OUT,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  P_DATA,
    input  Data_valid,
    input  PAR_EN,
    input  PAR_TYP,
    input  STOP2,
    output TX_OUT,
    output busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// Load-and-shift register for one UART word, with the bit counter and the even parity of the loaded word.
// bit_out always presents the next data bit still to be sent.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CW         = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic                  cnt_clr,
  input  logic                  cnt_inc,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bit_out,
  output logic                  last_bit,
  output logic                  parity,
  output logic [CW-1:0]         cnt
);

  logic [DATA_WIDTH-1:0] sreg;
  logic                  par_q;

  // The counter and the shifter are controlled separately because the output flop
  // consumes a bit one edge before the counter reaches that bit's position.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg  <= '0;
      cnt   <= '0;
      par_q <= 1'b0;
    end else if (load) begin
      sreg  <= data_in;
      cnt   <= '0;
      par_q <= ^data_in;
    end else begin
      if (shift_en) begin
        sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bit_out  = sreg[0];
  assign last_bit = (cnt == CW'(DATA_WIDTH - 1));
  assign parity   = par_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: start, DATA_WIDTH data bits LSB first, optional parity, and one or two stop bits.
// CLK is the baud clock. A new word can be accepted in the final stop cycle for gap-free frames.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CW         = $clog2(DATA_WIDTH)
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_frame_if.slave  bus
);

  state_e          state_q;
  state_e          state_d;
  logic            tx_q;
  logic            tx_d;
  logic            par_en_q;
  logic            par_typ_q;
  logic            stop2_q;
  logic            accept;
  logic            final_stop;
  logic            ser_bit;
  logic            last_bit;
  logic            even_par;
  logic [CW-1:0]   cnt;

  assign final_stop = (state_q == STOP) &&
                      (cnt == ((stop2_q == STOP_TWO) ? CW'(1) : CW'(0)));
  assign accept     = bus.Data_valid && ((state_q == IDLE) || final_stop);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift_en (state_d == DATA),
    .cnt_clr  (state_d != state_q),
    .cnt_inc  ((state_q == DATA) || (state_q == STOP)),
    .data_in  (bus.P_DATA),
    .bit_out  (ser_bit),
    .last_bit (last_bit),
    .parity   (even_par),
    .cnt      (cnt)
  );

  // The line value is derived from the next state, so TX_OUT is a flop that lines up with the state.
  always_comb begin
    state_d = IDLE;
    tx_d    = 1'b1;
    case (state_q)
      IDLE:    state_d = accept ? START : IDLE;
      START:   state_d = DATA;
      DATA:    state_d = last_bit ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = STOP;
      STOP:    state_d = final_stop ? (accept ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = ser_bit;
      PARITY:  tx_d = parity_bit(even_par, par_typ_q);
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= STOP_ONE;
    end else if (accept) begin
      par_en_q  <= bus.PAR_EN;
      par_typ_q <= bus.PAR_TYP;
      stop2_q   <= bus.STOP2;
    end
  end

  assign bus.TX_OUT  = tx_q;
  assign bus.busy    = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);
  assign bus.tx_done = final_stop;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit engine: accepts a parallel word on a valid strobe and serialises it as start / data (LSB first) / optional parity / 1 or 2 stop bits, one bit per CLK (CLK is the baud-rate clock). It is the next-generation replacement for the fixed 8-bit TX controller, serializer and parity path. It adds configurable data width, odd/even parity, selectable stop-bit count, back-to-back frames without an idle gap, and a done pulse. It sits between the system-side TX data source and the serial line pin.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 2..16.
- CLK  input  1  baud-rate clock, all flops on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word, sampled only on an accept cycle.
- Data_valid  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = insert parity bit; sampled on an accept cycle.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on an accept cycle.
- STOP2  input  1  0 = one stop bit, 1 = two stop bits; sampled on an accept cycle.
- TX_OUT  output  1  serial line, registered, idle-high.
- busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse marking the final stop-bit cycle.

## Operation
- Reset values: TX_OUT=1, busy=0, tx_done=0. State is IDLE; bit counter, shift register and config latches are cleared.
- Accept condition: Data_valid=1 at a rising edge while in IDLE, or while in the final stop-bit cycle. At any other time Data_valid is ignored; there is no queueing.
- On accept, the block latches P_DATA, PAR_EN, PAR_TYP and STOP2. Input changes after that point do not affect the frame in flight.
- Parity bit is computed from the latched word: even = XOR of the data bits, odd = NOT of that XOR.
- States (one-hot) and transitions:
  - IDLE: goes to START on accept.
  - START: lasts 1 cycle, then goes to DATA.
  - DATA: lasts DATA_WIDTH cycles. The counter runs 0..DATA_WIDTH-1; the state exits at DATA_WIDTH-1, to PARITY if the latched PAR_EN=1, otherwise to STOP.
  - PARITY: lasts 1 cycle, then goes to STOP.
  - STOP: lasts 1 or 2 cycles according to the latched STOP2. From the final cycle it goes to START on accept, otherwise to IDLE.
- TX_OUT value per state:
  - IDLE: 1.
  - START: 0.
  - DATA: bit[counter] of the latched word.
  - PARITY: the parity bit.
  - STOP: 1.
- Illegal or unused state encodings recover to IDLE with TX_OUT=1.
- Bit counter width is $clog2(DATA_WIDTH). The counter resets to 0 on entry to DATA and on entry to STOP.

## Timing
- Accept happens at edge k. The start bit appears on TX_OUT in the cycle after edge k.
- Frame length: 1 + DATA_WIDTH + PAR_EN + (1 + STOP2) cycles.
- busy rises in the START cycle and stays high through the final stop cycle. On a back-to-back accept, busy stays high continuously with zero idle cycles between frames.
- tx_done is high exactly during the final stop-bit cycle and is decoded from state and counter. It also pulses on a back-to-back frame.
- Asynchronous reset mid-frame aborts the frame immediately: TX_OUT=1, busy=0, tx_done=0. No partial frame resumes after RST is released.
- Data_valid arriving at the same edge as reset release is ignored; the first accept is possible on the next edge.

## Structure
- Package uart_tx_pkg holds:
  - one-hot state constants IDLE, START, DATA, PARITY, STOP (5-bit);
  - PAR_EVEN=0 and PAR_ODD=1;
  - the STOP_ONE / STOP_TWO encodings.
- One sub-module, uart_tx_serializer(DATA_WIDTH):
  - load-and-shift register with bit counter, load and shift-enable inputs;
  - outputs the current bit, a last-bit flag and the parity bit of the loaded word.
- The top level holds the FSM, the config latches and the TX_OUT output flop.

## Test plan
- Reset: hold RST=0 with Data_valid=1 → TX_OUT=1, busy=0, tx_done=0 throughout; the first frame starts only after RST is released.
- Even parity: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, STOP2=0 → TX_OUT 0,1,0,1,0,0,1,0,1,0,1 (11 cycles). busy is high for 11 cycles; tx_done pulses in cycle 11.
- Odd parity, two stop bits: P_DATA=8'h01, PAR_EN=1, PAR_TYP=1, STOP2=1 → TX_OUT 0,1,0,0,0,0,0,0,0,0,1,1 (12 cycles); the parity bit is 0.
- Back-to-back: 8'h55 then 8'h0F with PAR_EN=0 and Data_valid high in the final stop cycle → two 10-cycle frames with no idle cycle between them. busy stays high for 20 cycles; tx_done pulses 10 cycles apart.
- Mid-frame request: during the DATA cycles of 8'h3C, assert Data_valid with P_DATA=8'hFF and toggle PAR_EN → 8'h3C frame is unchanged and 8'hFF is never sent.
- Reset mid-frame: assert RST=0 during data bit 3 → TX_OUT=1 and busy=0 immediately. After release, the next accept sends a complete, correct frame.
